// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use stalls, branch flushes, memory waits.
// Optional HAZARD_PERF_EN adds stall_count/flush_count performance counters.
module hazard_stall_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_hold,
    output logic        mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam int unsigned CNT_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES
                                                                         : FLUSH_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BUSY_W  = 8;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BUSY_W-1:0]   busy_q, busy_d;
    logic                timeout_q;
    logic                load_use;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // State, stall/flush counter, busy counter and sticky timeout flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            busy_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_q || (busy_d >= BUSY_W'(MEM_TIMEOUT));
        end
    end

    // Saturating count of consecutive busy cycles
    always_comb begin
        busy_d = '0;
        if (mem_busy) begin
            busy_d = (busy_q == {BUSY_W{1'b1}}) ? busy_q : busy_q + BUSY_W'(1);
        end
    end

    // Next state and combinational output decode; priority mem_busy > branch > load-use
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;

        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_hold    = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = ST_LOAD_STALL;
                            cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                ST_LOAD_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
    // Outside reset, pc_write is low only for load-use stalls or memory waits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_write) begin
                stall_count <= stall_count + 32'd1;
            end
            if (if_id_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a default-parameter instance and one with
// LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2, MEM_TIMEOUT=3 share the same stimulus.
module tb_hazard_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy;

    logic pcw_d, ifw_d, fl_d, bub_d, hold_d, to_d;
    logic pcw_c, ifw_c, fl_c, bub_c, hold_c, to_c;
`ifdef HAZARD_PERF_EN
    logic [31:0] sc_d, fc_d, sc_c, fc_c;
    int unsigned exp_sc_d, exp_fc_d, exp_sc_c, exp_fc_c;
`endif

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout}
    localparam logic [5:0] V_RUN   = 6'b110000;
    localparam logic [5:0] V_STALL = 6'b000100;
    localparam logic [5:0] V_FLUSH = 6'b111100;
    localparam logic [5:0] V_HOLD  = 6'b000010;
    localparam logic [5:0] V_RST   = 6'b001100;

    logic [5:0] obs_d, obs_c;
    assign obs_d = {pcw_d, ifw_d, fl_d, bub_d, hold_d, to_d};
    assign obs_c = {pcw_c, ifw_c, fl_c, bub_c, hold_c, to_c};

    logic [5:0] q_d[$];
    logic [5:0] q_c[$];
    logic       to_cfg;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    hazard_stall_ctrl u_def (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pcw_d), .if_id_write(ifw_d), .if_id_flush(fl_d),
        .id_ex_bubble(bub_d), .pipe_hold(hold_d), .mem_timeout(to_d)
`ifdef HAZARD_PERF_EN
        , .stall_count(sc_d), .flush_count(fc_d)
`endif
    );

    hazard_stall_ctrl #(
        .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .MEM_TIMEOUT(3)
    ) u_cfg (
        .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pcw_c), .if_id_write(ifw_c), .if_id_flush(fl_c),
        .id_ex_bubble(bub_c), .pipe_hold(hold_c), .mem_timeout(to_c)
`ifdef HAZARD_PERF_EN
        , .stall_count(sc_c), .flush_count(fc_c)
`endif
    );

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                          input logic [4:0] xrt);
        ex_mem_read = 1'b1; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; ex_rt = xrt;
    endtask

    // One clock with current inputs: queue expectations, compare at negedge, advance past posedge
    task automatic cycle(input logic [5:0] e_def, input logic [5:0] e_cfg, input string name);
        logic [5:0] ed, ec;
        q_d.push_back(e_def);
        q_c.push_back(e_cfg | {5'b0, to_cfg});
`ifdef HAZARD_PERF_EN
        if (reset_n) begin
            if (!e_def[5]) exp_sc_d++;
            if (e_def[3])  exp_fc_d++;
            if (!e_cfg[5]) exp_sc_c++;
            if (e_cfg[3])  exp_fc_c++;
        end
`endif
        @(negedge clock);
        ed = q_d.pop_front();
        ec = q_c.pop_front();
        checks++;
        if (obs_d !== ed) begin
            errors++;
            $display("FAIL %s dut=def got=%b exp=%b", name, obs_d, ed);
        end
        checks++;
        if (obs_c !== ec) begin
            errors++;
            $display("FAIL %s dut=cfg got=%b exp=%b", name, obs_c, ec);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_perf_model();
`ifdef HAZARD_PERF_EN
        exp_sc_d = 0; exp_fc_d = 0; exp_sc_c = 0; exp_fc_c = 0;
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        to_cfg  = 1'b0;
        idle_inputs();
        clear_perf_model();
        cycle(V_RST, V_RST, "rst_held");
        cycle(V_RST, V_RST, "rst_held2");
        reset_n = 1'b1;
        cycle(V_RUN, V_RUN, "rst_release");
        // asynchronous assertion in the middle of a cycle
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs_d !== V_RST) begin
            errors++;
            $display("FAIL rst_async dut=def got=%b exp=%b", obs_d, V_RST);
        end
        checks++;
        if (obs_c !== V_RST) begin
            errors++;
            $display("FAIL rst_async dut=cfg got=%b exp=%b", obs_c, V_RST);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        cycle(V_RUN, V_RUN, "rst_release2");
    endtask

    task automatic test_load_use();
        set_lu(5'd8, 5'd0, 1'b0, 5'd8);
        cycle(V_STALL, V_STALL, "lu_rs");
        idle_inputs();
        cycle(V_RUN, V_STALL, "lu_rs_after1");
        cycle(V_RUN, V_STALL, "lu_rs_after2");
        cycle(V_RUN, V_RUN, "lu_rs_done");
        set_lu(5'd0, 5'd0, 1'b0, 5'd0);
        cycle(V_RUN, V_RUN, "lu_rt_zero");
        idle_inputs();
    endtask

    task automatic test_extended_stall();
        set_lu(5'd3, 5'd8, 1'b0, 5'd8);
        cycle(V_RUN, V_RUN, "lu_rt_unused");
        set_lu(5'd3, 5'd8, 1'b1, 5'd8);
        cycle(V_STALL, V_STALL, "lu_rt_used");
        // lu and branch arriving while the long stall runs are ignored by cfg
        branch_taken = 1'b1;
        ex_mem_read  = 1'b0;
        cycle(V_FLUSH, V_STALL, "stall_ignores_branch");
        idle_inputs();
        set_lu(5'd8, 5'd0, 1'b0, 5'd8);
        cycle(V_STALL, V_STALL, "stall_ignores_lu");
        idle_inputs();
        cycle(V_RUN, V_RUN, "stall_done");
    endtask

    task automatic test_branch();
        set_lu(5'd8, 5'd0, 1'b0, 5'd8);
        branch_taken = 1'b1;
        cycle(V_FLUSH, V_FLUSH, "br_with_lu");
        idle_inputs();
        cycle(V_RUN, V_FLUSH, "br_flush2");
        cycle(V_RUN, V_RUN, "br_done");
        branch_taken = 1'b1;
        cycle(V_FLUSH, V_FLUSH, "br_again");
        cycle(V_FLUSH, V_FLUSH, "br_in_flush");
        branch_taken = 1'b0;
        cycle(V_RUN, V_RUN, "br_ignored_done");
    endtask

    task automatic test_mem_wait();
        mem_busy = 1'b1; branch_taken = 1'b1;
        cycle(V_HOLD, V_HOLD, "busy_over_branch");
        idle_inputs();
        cycle(V_RUN, V_RUN, "busy_branch_dropped");
        set_lu(5'd8, 5'd0, 1'b0, 5'd8);
        cycle(V_STALL, V_STALL, "mw_lu");
        idle_inputs();
        mem_busy = 1'b1;
        cycle(V_HOLD, V_HOLD, "mw_hold1");
        cycle(V_HOLD, V_HOLD, "mw_hold2");
        cycle(V_HOLD, V_HOLD, "mw_hold3");
        to_cfg = 1'b1;
        cycle(V_HOLD, V_HOLD, "mw_hold4_timeout");
        mem_busy = 1'b0;
        cycle(V_RUN, V_STALL, "mw_resume1");
        cycle(V_RUN, V_STALL, "mw_resume2");
        cycle(V_RUN, V_RUN, "mw_done_sticky");
    endtask

    task automatic test_perf();
`ifdef HAZARD_PERF_EN
        checks++;
        if (sc_d !== 32'(exp_sc_d)) begin
            errors++; $display("FAIL stall_count dut=def got=%0d exp=%0d", sc_d, exp_sc_d);
        end
        checks++;
        if (fc_d !== 32'(exp_fc_d)) begin
            errors++; $display("FAIL flush_count dut=def got=%0d exp=%0d", fc_d, exp_fc_d);
        end
        checks++;
        if (sc_c !== 32'(exp_sc_c)) begin
            errors++; $display("FAIL stall_count dut=cfg got=%0d exp=%0d", sc_c, exp_sc_c);
        end
        checks++;
        if (fc_c !== 32'(exp_fc_c)) begin
            errors++; $display("FAIL flush_count dut=cfg got=%0d exp=%0d", fc_c, exp_fc_c);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        set_lu(5'd8, 5'd0, 1'b0, 5'd8);
        cycle(V_STALL, V_STALL, "rm_lu");
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs_c !== V_RST) begin
            errors++;
            $display("FAIL rst_mid_stall dut=cfg got=%b exp=%b", obs_c, V_RST);
        end
        to_cfg = 1'b0;
        clear_perf_model();
        @(posedge clock);
        #1 reset_n = 1'b1;
        cycle(V_RUN, V_RUN, "rm_aborted");
        test_perf();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_extended_stall();
        test_branch();
        test_mem_wait();
        test_perf();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline controller for the 5-stage MIPS core.
- Sequences the PC and the IF/ID register: generates PC write-enable, IF/ID write-enable/flush and the ID/EX bubble.
- Handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Sits beside IF/ID; consumes ID-stage register fields and EX-stage control.

Parameters:
- LOAD_STALL_CYCLES, 1: total stall cycles per load-use hazard (≥1).
- FLUSH_CYCLES, 1: cycles of flush per taken branch (≥1).
- MEM_TIMEOUT, 255: consecutive mem_busy cycles that set mem_timeout (≥1, ≤255).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of instruction in IF/ID.
- id_rt  in  5  rt field of instruction in IF/ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in ID/EX is a load.
- ex_rt  in  5  destination rt of instruction in ID/EX.
- branch_taken  in  1  branch resolved taken this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID loads NOP (32'h0).
- id_ex_bubble  out  1  ID/EX control fields forced to zero.
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT.

Behaviour:
- Clock and reset: one clock domain. reset_n low asynchronously forces state RUN, all counters 0 and mem_timeout=0.
- Outputs during reset: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
- Output timing: state and counters are registered. Outputs are a combinational decode of the current state and current-cycle inputs, so there is 0-cycle response to a hazard.
- Load-use condition (lu): ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Default (RUN, no event): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_hold=0.
- Priority each cycle: mem_busy > branch_taken > lu.
- mem_busy=1, any state:
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, pipe_hold=1.
  - State and stall/flush counters hold. Pending LOAD_STALL/FLUSH resumes unchanged after busy drops.
- Busy counter: increments on each consecutive mem_busy cycle (saturating 8-bit) and clears when mem_busy=0. When it reaches MEM_TIMEOUT, mem_timeout=1 and stays 1 until reset.
- RUN:
  - branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. Next state FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - lu (no branch): pc_write=0, if_id_write=0, id_ex_bubble=1. Next state LOAD_STALL with cnt=LOAD_STALL_CYCLES-1 if LOAD_STALL_CYCLES>1, else RUN.
- LOAD_STALL:
  - Outputs as lu stall (pc_write=0, if_id_write=0, id_ex_bubble=1); cnt decrements.
  - cnt==1 → RUN next cycle.
  - branch_taken and lu are ignored in this state; EX holds a bubble.
- FLUSH:
  - Outputs as branch flush; cnt decrements; cnt==1 → RUN next cycle.
  - branch_taken is ignored in this state.
- Simultaneous branch_taken and lu in RUN: branch wins and no stall follows; the dependent instruction is flushed.
- Reset mid-stall or mid-flush aborts immediately to RUN with reset outputs.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Extra output ports stall_count[31:0] and flush_count[31:0], reset to 0, wrapping modulo 2^32.
  - stall_count increments each cycle pc_write=0 due to lu/LOAD_STALL or mem_busy.
  - flush_count increments each cycle if_id_flush=1 outside reset.
- When undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle → pc_write=0, if_id_flush=1, id_ex_bubble=1, mem_timeout=0 immediately. Release → RUN defaults next cycle.
- Load-use: ex_mem_read=1, ex_rt=5'd8, id_rs=5'd8 (default params) → one cycle pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle all defaults. With ex_rt=0, no stall.
- Extended stall: LOAD_STALL_CYCLES=3 → exactly 3 consecutive stall cycles. Same test with id_rt=5'd8 and id_uses_rt=0 → no stall.
- Branch: branch_taken=1 with lu simultaneously, FLUSH_CYCLES=2 → 2 cycles if_id_flush=1, id_ex_bubble=1, pc_write=1, and no stall cycles.
- Mem wait: mem_busy=1 for 4 cycles during LOAD_STALL (LOAD_STALL_CYCLES=3) → pipe_hold=1 for 4 cycles. Stall then completes its remaining count. MEM_TIMEOUT=3 → mem_timeout rises after 3rd busy cycle and stays 1 after busy drops.
- Perf (HAZARD_PERF_EN): run the above sequence → stall_count and flush_count equal the scoreboard totals.
